// File: rtl/rv32i_pkg.sv
// Shared core definitions: register-file geometry, write-back request type
// and the fixed write-back source indices.
package rv32i_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN_DEF   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;

endpackage

// File: rtl/rv32i_rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester at or after the
// pointer and advances the pointer past the winner on every grant.
module rv32i_rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            k_c;

    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        k_c       = 0;
        for (int i = 0; i < N; i++) begin
            k_c = int'(ptr_q) + i;
            if (k_c >= N) k_c = k_c - N;
            if (!found && req_i[PW'(k_c)]) begin
                found     = 1'b1;
                gnt_idx_o = PW'(k_c);
            end
        end
    end

    // Grant is suppressed during reset so nothing handshakes while rst_n is low.
    assign gnt_vld_o = found & rst_n;
    assign gnt_o     = gnt_vld_o ? (N'(1) << gnt_idx_o) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// pending-write busy scoreboard for the issue stage.
module rv32i_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [NUM_SRC*5-1:0]    src_addr,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic                    rsv_en,
    input  logic [4:0]              rsv_addr,
    output logic                    wr_en,
    output logic [4:0]              wr_addr,
    output logic [XLEN-1:0]         wr_data,
    output logic [NUM_REGS-1:0]     busy
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]         gnt_idx;
    logic                  gnt_vld;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]       wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    rv32i_rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (src_valid),
        .gnt_o     (src_ready),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign sel_addr = src_addr[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = src_data[gnt_idx*XLEN +: XLEN];

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        if (gnt_vld) begin
            wr_en_d   = (sel_addr != '0);
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            if (sel_addr != '0) busy_d[sel_addr] = 1'b0;
        end
        // Applied after the clear: a fresh reservation supersedes the commit.
        if (rsv_en && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule
